imm_encode_loader: RTL and testbench
====================================

Name: imm_encode_loader

Overview:
- Inverse of the core's immediate decode path: packs instruction fields plus an architectural immediate into a 32-bit RV32I instruction word.
- Streams the encoded words into instruction memory at consecutive word addresses.
- Sits between the test/boot loader and the instruction RAM. Used to build merge-sort programs in RAM before the core is released from reset.
- Performs immediate range checking and supports memory back-pressure.

Parameters:
- ADDR_W, 10, instruction-memory word-address width
- CNT_W, 10, width of the program word counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches base_addr and word_count, begins a load
- base_addr  in  ADDR_W  first word address to write
- word_count  in  CNT_W  number of instructions to load (0 = load nothing, immediate done)
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block accepts fields this cycle
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHIFT (I-type with shamt), 7=reserved
- opcode  in  7  inst[6:0]
- rd, rs1, rs2  in  5 each  register fields
- funct3  in  3  inst[14:12]
- funct7  in  7  inst[31:25] (R and SHIFT only)
- imm  in  32  architectural immediate value (byte offset for B/J, full upper value for U)
- mem_we  out  1  write strobe / valid to instruction RAM
- mem_ready  in  1  RAM accepts write this cycle
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when the last word is accepted by RAM
- err_range  out  1  sticky; immediate out of range or fmt=7

Behaviour:
- Reset: all outputs 0 (mem_we, mem_addr, mem_wdata, busy, done, err_range, in_ready); FSM enters IDLE.
- FSM states: IDLE, RUN, ERR.
- IDLE, on start:
  - If word_count=0: pulse done next cycle and remain IDLE.
  - Otherwise: addr_ptr<=base_addr, remaining<=word_count, err_range<=0, enter RUN.
- RUN:
  - in_ready = !out_full || mem_ready, and accepted_count < word_count. No combinational path from in_valid to in_ready.
  - Transfer on in_valid && in_ready.
  - The encoded word is registered; mem_we rises the cycle after transfer (latency 1).
  - mem_we/addr/wdata are held stable while mem_ready=0.
  - On mem_we && mem_ready: addr_ptr increments, wrapping modulo 2^ADDR_W; remaining decrements.
  - Back-to-back transfers are allowed: when RAM accepts a word in the same cycle a new one transfers, full throughput is 1 word/cycle.
  - When remaining reaches 0 on a RAM acceptance: pulse done, return to IDLE.
- Encoding (standard RV32I):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - SHIFT: {funct7, imm[4:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Range rules, checked at transfer:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - SHIFT: imm[31:5]=0.
  - R: imm ignored.
  - fmt=7 is always an error.
- Range violation:
  - The offending word is not written.
  - err_range<=1 and the FSM enters ERR.
  - Any word already registered still completes its RAM write.
  - In ERR: in_ready=0, busy=1 until the pending output drains, then busy=0. err_range holds until the next start.
- start while RUN or ERR: ignored.
- busy = (state!=IDLE) || mem_we.
- rst_n deasserted mid-load: immediate abort. mem_we drops asynchronously; the partial program is left in RAM.

Test Plan:
- start base=0x010, count=2; feed I addi x1,x0,-1 (opcode 0x13, f3 0, imm 0xFFFFFFFF) then U lui x2,0x12345000 (opcode 0x37) with mem_ready=1 -> addr 0x010 data 0xFFF00093, addr 0x011 data 0x12345137, done pulse on cycle after second write, busy low.
- B beq x1,x2,-8 (opcode 0x63, imm 0xFFFFFFF8) -> 0xFE208CE3; J jal x1,+2048 (opcode 0x6F, imm 0x800) -> 0x001000EF.
- mem_ready held 0 for 3 cycles with in_valid continuous -> second word accepted (out_full, in_ready low), mem_addr/wdata stable, no word lost or duplicated, addresses consecutive after release.
- S imm=0x800 (out of range) as 2nd of 3 words -> word 1 written, err_range=1, no further mem_we, busy falls, done never pulses; next start clears err_range.
- base_addr=2^ADDR_W-1, count=2 -> writes at 0x3FF then 0x000; start with count=0 -> done pulse, no mem_we.
- rst_n low mid-stream with mem_we=1 -> mem_we=0 immediately, all outputs 0, IDLE; subsequent start works normally.

Source files
------------

// File: rtl/imm_encode_loader_if.sv
// Loader-facing bundle: load control, instruction-field handshake and the
// instruction-RAM write port. "slave" is the encoder side, "master" the driver.
interface imm_encode_loader_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 10
);
  // load control and status
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              busy;
  logic              done;
  logic              err_range;

  // instruction-field handshake
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;

  // instruction-RAM write port
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  start, base_addr, word_count,
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
    input  mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output busy, done, err_range
  );

  modport master (
    output start, base_addr, word_count,
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
    output mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  busy, done, err_range
  );
endinterface

// File: rtl/imm_encode_loader.sv
// Packs RV32I fields plus an architectural immediate into instruction words and
// streams them into instruction RAM at consecutive addresses, with range checks.
module imm_encode_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 10
) (
  input logic               clk,
  input logic               rst_n,
  imm_encode_loader_if.slave bus
);

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHIFT = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  accepted_q, accepted_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_full_q, out_full_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [31:0]       enc_word_c;
  logic              range_ok_c;
  logic              in_ready_c;
  logic              xfer_c;
  logic              mem_fire_c;

  // Output register frees up when empty or when RAM takes its word this cycle
  assign in_ready_c = (state_q == ST_RUN) && (!out_full_q || bus.mem_ready) &&
                      (accepted_q != count_q);
  assign xfer_c     = bus.in_valid && in_ready_c;
  assign mem_fire_c = out_full_q && bus.mem_ready;

  // Field packing and immediate range check for the presented fields
  always_comb begin
    enc_word_c = 32'h0;
    range_ok_c = 1'b0;
    case (bus.fmt)
      FMT_R: begin
        enc_word_c = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
        range_ok_c = 1'b1;
      end
      FMT_I: begin
        enc_word_c = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        range_ok_c = (&bus.imm[31:11]) || !(|bus.imm[31:11]);
      end
      FMT_S: begin
        enc_word_c = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0],
                      bus.opcode};
        range_ok_c = (&bus.imm[31:11]) || !(|bus.imm[31:11]);
      end
      FMT_B: begin
        enc_word_c = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                      bus.imm[4:1], bus.imm[11], bus.opcode};
        range_ok_c = ((&bus.imm[31:12]) || !(|bus.imm[31:12])) && !bus.imm[0];
      end
      FMT_U: begin
        enc_word_c = {bus.imm[31:12], bus.rd, bus.opcode};
        range_ok_c = !(|bus.imm[11:0]);
      end
      FMT_J: begin
        enc_word_c = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                      bus.rd, bus.opcode};
        range_ok_c = ((&bus.imm[31:20]) || !(|bus.imm[31:20])) && !bus.imm[0];
      end
      FMT_SHIFT: begin
        enc_word_c = {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd,
                      bus.opcode};
        range_ok_c = !(|bus.imm[31:5]);
      end
      default: begin
        enc_word_c = 32'h0;
        range_ok_c = 1'b0;
      end
    endcase
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    accepted_d  = accepted_q;
    count_d     = count_q;
    out_full_d  = out_full_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.word_count == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = bus.base_addr;
            remaining_d = bus.word_count;
            accepted_d  = '0;
            count_d     = bus.word_count;
            err_d       = 1'b0;
            state_d     = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (mem_fire_c) begin
          out_full_d  = 1'b0;
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        if (xfer_c) begin
          if (range_ok_c) begin
            out_full_d = 1'b1;
            wdata_d    = enc_word_c;
            accepted_d = accepted_q + CNT_W'(1);
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        // Let an already-registered word finish, then drop back to idle
        if (mem_fire_c) begin
          out_full_d  = 1'b0;
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
        end
        if (!out_full_d) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) || out_full_d;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      accepted_q  <= '0;
      count_q     <= '0;
      out_full_q  <= 1'b0;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      accepted_q  <= accepted_d;
      count_q     <= count_d;
      out_full_q  <= out_full_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_we    = out_full_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_range = err_q;

endmodule

// File: tb/tb_imm_encode_loader.sv
// Bench for imm_encode_loader: table of single-word encodings, directed
// multi-cycle sequences, and randomized loads against a behavioural model.
module tb_imm_encode_loader;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CNT_W  = 10;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } fld_t;

  typedef struct {
    fld_t        f;
    logic [31:0] word;
    bit          err;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;

  imm_encode_loader_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  imm_encode_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  int   done_cnt = 0;
  int   hold_viol = 0;
  wr_t  got_q[$];
  wr_t  exp_q[$];
  fld_t flds[$];
  int   g_gb, g_db, g_hb;
  bit   prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [31:0]       prev_data;

  // RAM-side ready generator, changes only just after the rising edge
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.mem_ready = 1'b1;
      1:       bus.mem_ready = ($urandom_range(0, 3) != 0);
      default: bus.mem_ready = 1'b0;
    endcase
  end

  // RAM model: records accepted writes, done pulses and hold violations
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (prev_stall && !(bus.mem_we === 1'b1 && bus.mem_addr === prev_addr &&
                          bus.mem_wdata === prev_data))
        hold_viol++;
      if (bus.mem_we === 1'b1 && bus.mem_ready === 1'b1)
        got_q.push_back('{bus.mem_addr, bus.mem_wdata});
      if (bus.done === 1'b1) done_cnt++;
      prev_stall = (bus.mem_we === 1'b1) && (bus.mem_ready !== 1'b1);
      prev_addr  = bus.mem_addr;
      prev_data  = bus.mem_wdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference legality: immediate must fit the format's signed/unsigned field
  function automatic bit model_bad(input fld_t f);
    longint s;
    s = longint'($signed(f.imm));
    case (f.fmt)
      3'd0:       return 1'b0;
      3'd1, 3'd2: return (s < -64'sd2048) || (s > 64'sd2047);
      3'd3:       return (s < -64'sd4096) || (s > 64'sd4095) || ((s % 2) != 0);
      3'd4:       return (f.imm % 32'd4096) != 32'd0;
      3'd5:       return (s < -64'sd1048576) || (s > 64'sd1048575) || ((s % 2) != 0);
      3'd6:       return f.imm > 32'd31;
      default:    return 1'b1;
    endcase
  endfunction

  // Copy n bits of src starting at bit lo into w at bit dst
  function automatic logic [31:0] put(input logic [31:0] w, input logic [31:0] src,
                                      input int lo, input int n, input int dst);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return 32'(64'(w) | (((64'(src) >> lo) & m) << dst));
  endfunction

  function automatic logic [31:0] model_enc(input fld_t f);
    logic [31:0] w;
    w = 32'(f.opcode);
    case (f.fmt)
      3'd0: begin
        w = put(w, 32'(f.rd), 0, 5, 7);   w = put(w, 32'(f.f3), 0, 3, 12);
        w = put(w, 32'(f.rs1), 0, 5, 15); w = put(w, 32'(f.rs2), 0, 5, 20);
        w = put(w, 32'(f.f7), 0, 7, 25);
      end
      3'd1: begin
        w = put(w, 32'(f.rd), 0, 5, 7);   w = put(w, 32'(f.f3), 0, 3, 12);
        w = put(w, 32'(f.rs1), 0, 5, 15); w = put(w, f.imm, 0, 12, 20);
      end
      3'd6: begin
        w = put(w, 32'(f.rd), 0, 5, 7);   w = put(w, 32'(f.f3), 0, 3, 12);
        w = put(w, 32'(f.rs1), 0, 5, 15); w = put(w, f.imm, 0, 5, 20);
        w = put(w, 32'(f.f7), 0, 7, 25);
      end
      3'd2: begin
        w = put(w, f.imm, 0, 5, 7);       w = put(w, 32'(f.f3), 0, 3, 12);
        w = put(w, 32'(f.rs1), 0, 5, 15); w = put(w, 32'(f.rs2), 0, 5, 20);
        w = put(w, f.imm, 5, 7, 25);
      end
      3'd3: begin
        w = put(w, f.imm, 11, 1, 7);      w = put(w, f.imm, 1, 4, 8);
        w = put(w, 32'(f.f3), 0, 3, 12);  w = put(w, 32'(f.rs1), 0, 5, 15);
        w = put(w, 32'(f.rs2), 0, 5, 20); w = put(w, f.imm, 5, 6, 25);
        w = put(w, f.imm, 12, 1, 31);
      end
      3'd4: begin
        w = put(w, 32'(f.rd), 0, 5, 7);   w = put(w, f.imm, 12, 20, 12);
      end
      3'd5: begin
        w = put(w, 32'(f.rd), 0, 5, 7);   w = put(w, f.imm, 12, 8, 12);
        w = put(w, f.imm, 11, 1, 20);     w = put(w, f.imm, 1, 10, 21);
        w = put(w, f.imm, 20, 1, 31);
      end
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic fld_t mk(input int fmt, input int op, input int rd, input int rs1,
                              input int rs2, input int f3, input int f7, input logic [31:0] imm);
    fld_t f;
    f.fmt = 3'(fmt); f.opcode = 7'(op); f.rd = 5'(rd); f.rs1 = 5'(rs1);
    f.rs2 = 5'(rs2); f.f3 = 3'(f3); f.f7 = 7'(f7); f.imm = imm;
    return f;
  endfunction

  function automatic fld_t rand_fld();
    fld_t f;
    logic [31:0] u;
    u = $urandom;
    f = mk($urandom_range(0, 6), $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, u);
    if ($urandom_range(0, 40) == 0) f.fmt = 3'd7;
    if ($urandom_range(0, 9) != 0) begin
      case (f.fmt)
        3'd1, 3'd2: f.imm = {{20{u[11]}}, u[11:0]};
        3'd3:       f.imm = {{19{u[12]}}, u[12:1], 1'b0};
        3'd4:       f.imm = {u[31:12], 12'h0};
        3'd5:       f.imm = {{11{u[20]}}, u[20:1], 1'b0};
        3'd6:       f.imm = {27'h0, u[4:0]};
        default:    f.imm = u;
      endcase
    end
    return f;
  endfunction

  task automatic drive_fields(input fld_t f);
    bus.fmt = f.fmt; bus.opcode = f.opcode; bus.rd = f.rd; bus.rs1 = f.rs1;
    bus.rs2 = f.rs2; bus.funct3 = f.f3; bus.funct7 = f.f7; bus.imm = f.imm;
    bus.in_valid = 1'b1;
  endtask

  // Present one field set until the block takes it (bounded)
  task automatic feed(input fld_t f, output bit ok);
    drive_fields(f);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
    exp_q.delete();
    g_gb = got_q.size(); g_db = done_cnt; g_hb = hold_viol;
    bus.start = 1'b1; bus.base_addr = base; bus.word_count = cnt;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Feed flds[], building the expected write list; stop after an illegal word
  task automatic feed_all(input string tag, input logic [ADDR_W-1:0] base, output bit bad);
    logic [ADDR_W-1:0] a;
    bit ok;
    a = base;
    bad = 1'b0;
    foreach (flds[i]) begin
      if (model_bad(flds[i])) bad = 1'b1;
      else begin
        exp_q.push_back('{a, model_enc(flds[i])});
        a = a + ADDR_W'(1);
      end
      feed(flds[i], ok);
      check($sformatf("%s_accept%0d", tag, i), 32'(ok), 32'd1);
      if (bad) break;
    end
  endtask

  task automatic finish_load(input string tag, input bit exp_done, input bit exp_err);
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        idle = 1'b1;
        break;
      end
    end
    check({tag, "_busy_falls"}, 32'(idle), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_nwrites"}, 32'(got_q.size() - g_gb), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && (g_gb + i) < got_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(got_q[g_gb + i].addr), 32'(exp_q[i].addr));
      check($sformatf("%s_data%0d", tag, i), got_q[g_gb + i].data, exp_q[i].data);
    end
    check({tag, "_done_pulses"}, 32'(done_cnt - g_db), 32'(exp_done));
    check({tag, "_err_range"}, 32'(bus.err_range), 32'(exp_err));
    check({tag, "_hold_stable"}, 32'(hold_viol - g_hb), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    bit bad, ok;
    logic [31:0] w1;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0;
    drive_fields(mk(0, 0, 0, 0, 0, 0, 0, 32'h0));
    bus.in_valid = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err_range), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single-word encodings with hand-derived words
    vecs.push_back('{mk(1, 7'h13, 1, 0, 0, 0, 0, 32'hFFFFFFFF), 32'hFFF00093, 1'b0});
    vecs.push_back('{mk(4, 7'h37, 2, 0, 0, 0, 0, 32'h12345000), 32'h12345137, 1'b0});
    vecs.push_back('{mk(3, 7'h63, 0, 1, 2, 0, 0, 32'hFFFFFFF8), 32'hFE208CE3, 1'b0});
    vecs.push_back('{mk(5, 7'h6F, 1, 0, 0, 0, 0, 32'h00000800), 32'h001000EF, 1'b0});
    vecs.push_back('{mk(0, 7'h33, 3, 1, 2, 0, 0, 32'hDEADBEEF), 32'h002081B3, 1'b0});
    vecs.push_back('{mk(0, 7'h33, 3, 1, 2, 0, 7'h20, 32'h0), 32'h402081B3, 1'b0});
    vecs.push_back('{mk(6, 7'h13, 5, 6, 0, 5, 7'h20, 32'h7), 32'h40735293, 1'b0});
    vecs.push_back('{mk(2, 7'h23, 0, 1, 2, 2, 0, 32'hFFFFFFFC), 32'hFE20AE23, 1'b0});
    vecs.push_back('{mk(1, 7'h13, 1, 0, 0, 0, 0, 32'h000007FF), 32'h7FF00093, 1'b0});
    vecs.push_back('{mk(1, 7'h13, 1, 0, 0, 0, 0, 32'hFFFFF800), 32'h80000093, 1'b0});
    vecs.push_back('{mk(3, 7'h63, 0, 0, 0, 0, 0, 32'h00000FFE), 32'h7E000FE3, 1'b0});
    vecs.push_back('{mk(5, 7'h6F, 0, 0, 0, 0, 0, 32'hFFFFFFFE), 32'hFFFFF06F, 1'b0});
    vecs.push_back('{mk(2, 7'h23, 0, 1, 2, 2, 0, 32'h00000800), 32'h0, 1'b1});
    vecs.push_back('{mk(1, 7'h13, 1, 0, 0, 0, 0, 32'h00000800), 32'h0, 1'b1});
    vecs.push_back('{mk(3, 7'h63, 0, 1, 2, 0, 0, 32'h00000007), 32'h0, 1'b1});
    vecs.push_back('{mk(3, 7'h63, 0, 1, 2, 0, 0, 32'h00001000), 32'h0, 1'b1});
    vecs.push_back('{mk(5, 7'h6F, 1, 0, 0, 0, 0, 32'h00100000), 32'h0, 1'b1});
    vecs.push_back('{mk(5, 7'h6F, 1, 0, 0, 0, 0, 32'h00000003), 32'h0, 1'b1});
    vecs.push_back('{mk(4, 7'h37, 2, 0, 0, 0, 0, 32'h12345001), 32'h0, 1'b1});
    vecs.push_back('{mk(6, 7'h13, 5, 6, 0, 1, 0, 32'h00000020), 32'h0, 1'b1});
    vecs.push_back('{mk(7, 7'h13, 1, 0, 0, 0, 0, 32'h0), 32'h0, 1'b1});

    foreach (vecs[i]) begin
      flds.delete();
      flds.push_back(vecs[i].f);
      start_load(ADDR_W'(32'h200 + i), CNT_W'(1));
      feed_all($sformatf("vec%0d", i), ADDR_W'(32'h200 + i), bad);
      check($sformatf("vec%0d_model_err", i), 32'(bad), 32'(vecs[i].err));
      finish_load($sformatf("vec%0d", i), !vecs[i].err, vecs[i].err);
      if (!vecs[i].err && got_q.size() > g_gb)
        check($sformatf("vec%0d_word", i), got_q[g_gb].data, vecs[i].word);
    end

    // two-word program, done after the second write
    flds.delete();
    flds.push_back(vecs[0].f);
    flds.push_back(vecs[1].f);
    start_load(ADDR_W'(32'h010), CNT_W'(2));
    feed_all("prog2", ADDR_W'(32'h010), bad);
    finish_load("prog2", 1'b1, 1'b0);
    check("prog2_busy_low", 32'(bus.busy), 32'd0);

    // back-pressure: RAM stalls for 3 cycles while the next word waits
    rdy_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flds.delete();
    for (int i = 0; i < 3; i++) flds.push_back(vecs[4 + i].f);
    start_load(ADDR_W'(32'h040), CNT_W'(3));
    for (int i = 0; i < 3; i++) exp_q.push_back('{ADDR_W'(32'h040 + i), model_enc(flds[i])});
    w1 = model_enc(flds[0]);
    feed(flds[0], ok);
    check("bp_accept0", 32'(ok), 32'd1);
    drive_fields(flds[1]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready%0d", k), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp_mem_we%0d", k), 32'(bus.mem_we), 32'd1);
      check($sformatf("bp_addr%0d", k), 32'(bus.mem_addr), 32'h040);
      check($sformatf("bp_wdata%0d", k), bus.mem_wdata, w1);
    end
    rdy_mode = 0;
    @(posedge clk); #1;
    feed(flds[1], ok);
    check("bp_accept1", 32'(ok), 32'd1);
    feed(flds[2], ok);
    check("bp_accept2", 32'(ok), 32'd1);
    finish_load("bp", 1'b1, 1'b0);

    // illegal second word of three
    flds.delete();
    flds.push_back(vecs[0].f);
    flds.push_back(vecs[12].f);
    flds.push_back(vecs[1].f);
    start_load(ADDR_W'(32'h080), CNT_W'(3));
    feed_all("errmid", ADDR_W'(32'h080), bad);
    finish_load("errmid", 1'b0, 1'b1);
    flds.delete();
    flds.push_back(vecs[2].f);
    start_load(ADDR_W'(32'h090), CNT_W'(1));
    check("err_cleared_by_start", 32'(bus.err_range), 32'd0);
    feed_all("after_err", ADDR_W'(32'h090), bad);
    finish_load("after_err", 1'b1, 1'b0);

    // address wrap at the top of RAM
    flds.delete();
    flds.push_back(vecs[3].f);
    flds.push_back(vecs[7].f);
    start_load(ADDR_W'(32'h3FF), CNT_W'(2));
    feed_all("wrap", ADDR_W'(32'h3FF), bad);
    finish_load("wrap", 1'b1, 1'b0);

    // zero-length load
    g_gb = got_q.size();
    bus.start = 1'b1; bus.base_addr = ADDR_W'(32'h123); bus.word_count = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("zero_done", 32'(bus.done), 32'd1);
    check("zero_busy", 32'(bus.busy), 32'd0);
    check("zero_mem_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    check("zero_done_one_cycle", 32'(bus.done), 32'd0);
    check("zero_nwrites", 32'(got_q.size() - g_gb), 32'd0);
    @(posedge clk); #1;

    // asynchronous reset while a write is pending
    rdy_mode = 2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flds.delete();
    for (int i = 0; i < 4; i++) flds.push_back(vecs[i].f);
    start_load(ADDR_W'(32'h100), CNT_W'(4));
    feed(flds[0], ok);
    check("rstmid_accept", 32'(ok), 32'd1);
    @(negedge clk);
    check("rstmid_pending", 32'(bus.mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_mem_we", 32'(bus.mem_we), 32'd0);
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    check("rstmid_done", 32'(bus.done), 32'd0);
    check("rstmid_err", 32'(bus.err_range), 32'd0);
    check("rstmid_in_ready", 32'(bus.in_ready), 32'd0);
    check("rstmid_addr", 32'(bus.mem_addr), 32'd0);
    check("rstmid_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flds.delete();
    flds.push_back(vecs[5].f);
    flds.push_back(vecs[6].f);
    start_load(ADDR_W'(32'h120), CNT_W'(2));
    feed_all("post_rst", ADDR_W'(32'h120), bad);
    finish_load("post_rst", 1'b1, 1'b0);

    // randomized loads with random RAM back-pressure
    rdy_mode = 1;
    for (int t = 0; t < 25; t++) begin
      int n;
      logic [ADDR_W-1:0] base;
      n = $urandom_range(1, 8);
      base = ADDR_W'($urandom);
      flds.delete();
      for (int i = 0; i < n; i++) flds.push_back(rand_fld());
      start_load(base, CNT_W'(n));
      feed_all($sformatf("rnd%0d", t), base, bad);
      finish_load($sformatf("rnd%0d", t), !bad, bad);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
